// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and the cache controllers that sit on it.
package mem_bus_arbiter_pkg;

    localparam int ADR_W_DEF = 32;
    localparam int DAT_W_DEF = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo N_REQ.
module mem_bus_arbiter_rr_picker #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin
        int unsigned k;
        k     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_i) + i) % N_REQ;
            if (!vld_o && req_i[k]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(k);
                gnt_o = N_REQ'(1) << k;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the single memory bus port; one locked transaction per grant.
//   state | meaning
//   IDLE  | no owner, arbitrate among cyc_i
//   BUSY  | owner latched, forwarding its cycle to memory
//   DONE  | one-cycle bus turnaround, cyc_m2s low
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DAT_W   = DAT_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       cyc_i,
    input  logic [N_REQ-1:0]       we_i,
    input  logic [N_REQ*ADR_W-1:0] adr_i,
    input  logic [N_REQ*DAT_W-1:0] dat_i,
    output logic [DAT_W-1:0]       dat_o,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       err_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   cyc_m2s,
    output logic                   we_m2s,
    output logic [ADR_W-1:0]       adr_m2s,
    output logic [DAT_W-1:0]       dat_m2s,
    input  logic [DAT_W-1:0]       dat_mem_i,
    input  logic                   ack_mem_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   src_idx;
    logic [IDX_W-1:0]   nxt_ptr;

    mem_bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i (cyc_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Bus fields come from the newly picked requester in IDLE, from the owner otherwise.
    assign src_idx = (state_q == IDLE) ? pick_idx : owner_q;
    assign nxt_ptr = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        err_d    = '0;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        ack_o    = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    grant_d = pick_gnt;
                    cyc_d   = 1'b1;
                    we_d    = we_i[src_idx];
                    adr_d   = adr_i[int'(src_idx)*ADR_W +: ADR_W];
                    dat_d   = dat_i[int'(src_idx)*DAT_W +: DAT_W];
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                we_d  = we_i[src_idx];
                adr_d = adr_i[int'(src_idx)*ADR_W +: ADR_W];
                dat_d = dat_i[int'(src_idx)*DAT_W +: DAT_W];
                if (!cyc_i[owner_q]) begin
                    // Abort keeps rr_ptr so the requester retains its priority.
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    grant_d = '0;
                end else if (ack_mem_i) begin
                    ack_o    = grant_q;
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    grant_d  = '0;
                    rr_ptr_d = nxt_ptr;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = grant_q;
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    grant_d  = '0;
                    rr_ptr_d = nxt_ptr;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                grant_d = '0;
            end
        endcase

        if (!rst) ack_o = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            err_q    <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dat_o   = dat_mem_i;
    assign err_o   = err_q;
    assign grant_o = grant_q;
    assign cyc_m2s = cyc_q;
    assign we_m2s  = we_q;
    assign adr_m2s = adr_q;
    assign dat_m2s = dat_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      cyc_i, we_i;
    logic [N*AW-1:0]   adr_i;
    logic [N*DW-1:0]   dat_i;
    logic [DW-1:0]     dat_o;
    logic [N-1:0]      ack_o, err_o, grant_o;
    logic              cyc_m2s, we_m2s;
    logic [AW-1:0]     adr_m2s;
    logic [DW-1:0]     dat_m2s;
    logic [DW-1:0]     dat_mem_i;
    logic              ack_mem_i;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N_REQ(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cyc_i     (cyc_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .grant_o   (grant_o),
        .cyc_m2s   (cyc_m2s),
        .we_m2s    (we_m2s),
        .adr_m2s   (adr_m2s),
        .dat_m2s   (dat_m2s),
        .dat_mem_i (dat_mem_i),
        .ack_mem_i (ack_mem_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, how long it has waited, whose turn is next.
    bit           m_busy, m_turn;
    int           m_own, m_rr, m_age;
    logic [N-1:0] m_grant, m_err;
    logic         m_cyc, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;

    logic [N*AW-1:0] adr_nx;
    logic [N*DW-1:0] dat_nx;

    logic [N-1:0] tr_err [12];
    logic [N-1:0] tr_gnt [12];
    logic         tr_cyc [12];
    logic [N-1:0] exp_seq [4];
    logic [N-1:0] cr;
    int           last, gi, hi;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst_v, input logic [N-1:0] cyc_v, input logic ack_v);
        m_err = '0;
        if (!rst_v) begin
            m_busy = 0; m_turn = 0; m_rr = 0; m_own = 0; m_age = 0;
        end else if (m_busy) begin
            m_we  = we_i[m_own];
            m_adr = adr_i[m_own*AW +: AW];
            m_dat = dat_i[m_own*DW +: DW];
            if (!cyc_v[m_own]) begin
                m_busy = 0; m_turn = 1;
            end else if (ack_v) begin
                m_busy = 0; m_turn = 1; m_rr = (m_own + 1) % N;
            end else if (m_age == TO - 1) begin
                m_busy = 0; m_turn = 1; m_rr = (m_own + 1) % N;
                m_err = N'(1) << m_own;
            end else begin
                m_age++;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k = (m_rr + i) % N;
                if (cyc_v[k]) begin
                    m_busy = 1; m_own = k; m_age = 0;
                    m_we  = we_i[k];
                    m_adr = adr_i[k*AW +: AW];
                    m_dat = dat_i[k*DW +: DW];
                    break;
                end
            end
        end
        m_cyc   = m_busy;
        m_grant = m_busy ? (N'(1) << m_own) : '0;
    endtask

    // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic step(input logic rst_v, input logic [N-1:0] cyc_v, input logic [N-1:0] we_v,
                        input logic ack_v, input logic [DW-1:0] dmem_v);
        logic [N-1:0] exp_ack;
        @(negedge clk);
        check_val("cyc_m2s", cyc_m2s, m_cyc);
        check_val("grant_o", grant_o, m_grant);
        check_val("err_o", err_o, m_err);
        if (m_cyc) begin
            check_val("we_m2s", we_m2s, m_we);
            check_val("adr_m2s", adr_m2s, m_adr);
            check_val("dat_m2s", dat_m2s, m_dat);
        end
        rst = rst_v; cyc_i = cyc_v; we_i = we_v; ack_mem_i = ack_v; dat_mem_i = dmem_v;
        adr_i = adr_nx; dat_i = dat_nx;
        #1;
        exp_ack = (rst_v && m_busy && cyc_v[m_own] && ack_v) ? (N'(1) << m_own) : '0;
        check_val("ack_o", ack_o, exp_ack);
        check_val("dat_o", dat_o, dmem_v);
        model_update(rst_v, cyc_v, ack_v);
    endtask

    initial begin
        rst = 1'b0; cyc_i = '0; we_i = '0; adr_i = '0; dat_i = '0;
        ack_mem_i = 1'b0; dat_mem_i = '0; adr_nx = '0; dat_nx = '0;
        m_busy = 0; m_turn = 0; m_own = 0; m_rr = 0; m_age = 0;
        m_grant = '0; m_err = '0; m_cyc = 0; m_we = 0; m_adr = '0; m_dat = '0;
        repeat (2) @(posedge clk);
        step(0, '0, '0, 0, '0);

        // single read, acked on third busy cycle
        adr_nx[0 +: AW] = 32'h100;
        step(1, 3'b001, 3'b000, 0, '0);
        step(1, 3'b001, 3'b000, 0, '0);
        check_val("rd_lat", cyc_m2s, 1);
        step(1, 3'b001, 3'b000, 0, '0);
        step(1, 3'b001, 3'b000, 1, 32'hDEAD);
        check_val("rd_ack", ack_o, 3'b001);
        check_val("rd_data", dat_o, 32'hDEAD);
        check_val("rd_adr", adr_m2s, 32'h100);
        step(1, '0, '0, 0, '0);
        check_val("rd_drop", cyc_m2s, 0);
        step(1, '0, '0, 0, '0);

        // write pass-through from requester 1
        adr_nx[AW +: AW] = 32'h40;
        dat_nx[DW +: DW] = 32'hCAFE;
        step(1, 3'b010, 3'b010, 0, '0);
        step(1, 3'b010, 3'b010, 0, '0);
        check_val("wr_we", we_m2s, 1);
        check_val("wr_adr", adr_m2s, 32'h40);
        check_val("wr_dat", dat_m2s, 32'hCAFE);
        step(1, 3'b010, 3'b010, 1, '0);
        check_val("wr_ack", ack_o, 3'b010);
        step(1, '0, '0, 0, '0);
        step(1, '0, '0, 0, '0);

        // contention: two requesters held, memory acks immediately
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
        last = -1; gi = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 3'b011, 3'b000, 1, 32'h5A5A);
            if (grant_o != '0) begin
                if (gi < 4) check_val($sformatf("rr_grant%0d", gi), grant_o, exp_seq[gi]);
                if (last >= 0) check_val("rr_gap", i - last, 3);
                last = i;
                gi++;
            end
        end
        check_val("rr_count", gi, 4);

        // timeout with requester 1 waiting behind requester 0
        for (int i = 0; i < 12; i++) begin
            step(1, 3'b011, 3'b000, 0, '0);
            tr_cyc[i] = cyc_m2s; tr_err[i] = err_o; tr_gnt[i] = grant_o;
        end
        hi = 0;
        for (int i = 1; i < 12 && tr_cyc[i]; i++) hi++;
        check_val("to_len", hi, TO);
        check_val("to_err", tr_err[5], 3'b001);
        check_val("to_err_1cyc", tr_err[6], 3'b000);
        check_val("to_next", tr_gnt[7], 3'b010);

        // abort in busy cycle 2 with a coincident memory ack
        step(1, 3'b001, 3'b000, 0, '0);
        step(1, 3'b001, 3'b000, 0, '0);
        step(1, 3'b000, 3'b000, 1, 32'hBEEF);
        check_val("ab_ack", ack_o, 3'b000);
        step(1, 3'b000, 3'b000, 0, '0);
        check_val("ab_drop", cyc_m2s, 0);
        check_val("ab_err", err_o, 3'b000);
        step(1, 3'b011, 3'b000, 0, '0);
        step(1, 3'b011, 3'b000, 1, '0);
        check_val("ab_prio", grant_o, 3'b001);
        step(1, '0, '0, 0, '0);
        step(1, '0, '0, 0, '0);

        // reset while busy
        step(1, 3'b010, 3'b010, 0, '0);
        step(1, 3'b010, 3'b010, 0, '0);
        check_val("rs_busy", cyc_m2s, 1);
        step(0, 3'b010, 3'b010, 1, '0);
        check_val("rs_ack", ack_o, 3'b000);
        step(1, '0, '0, 0, '0);
        check_val("rs_cyc", cyc_m2s, 0);
        check_val("rs_gnt", grant_o, 3'b000);
        check_val("rs_err", err_o, 3'b000);
        check_val("rs_we", we_m2s, 0);
        check_val("rs_adr", adr_m2s, 32'h0);
        check_val("rs_dat", dat_m2s, 32'h0);
        step(1, 3'b011, 3'b000, 0, '0);
        step(1, 3'b011, 3'b000, 1, '0);
        check_val("rs_ptr", grant_o, 3'b001);

        // random traffic
        cr = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < N; k++) begin
                if (cr[k]) begin
                    if ($urandom_range(0, (m_busy && m_own == k) ? 19 : 5) == 0) cr[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cr[k] = 1'b1;
                end
                adr_nx[k*AW +: AW] = $urandom;
                dat_nx[k*DW +: DW] = $urandom;
            end
            step($urandom_range(0, 149) != 0, cr, N'($urandom), $urandom_range(0, 2) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
